nand_bringup_seq: RTL and testbench
===================================

# nand_bringup_seq

Power-up sequencer consuming the clock/reset outputs of the NAND clocking infrastructure. After reset releases and the MMCM and IDELAYCTRL report ready, it waits a settle interval, releases the NAND PHY reset, issues the ONFI RESET command (0xFF) to each chip in turn, and waits for each chip's R/B# to return high with a timeout. It then reports `init_done` and a per-chip error mask to the flash controller.

## Interface
Parameters:
- NUM_CHIPS, 8, number of chip enables/R/B# lines; ≥1, ≤16.
- SETTLE_CYCLES, 1000, clk0 cycles of stable locked & idelay_ctrl_rdy before PHY release; ≥1.
- TWB_CYCLES, 10, wait after command acceptance before sampling R/B#; ≥1.
- TIMEOUT_CYCLES, 100000, max poll cycles per chip (1 ms at 100 MHz); < 2^20.

Ports:
- clk0  in  1  system clock, 100 MHz.
- rst_tmp  in  1  reset, asynchronous, active-high; clock clk0.
- locked  in  1  MMCM lock, async to clk0 (already implied by rst_tmp; also sampled).
- idelay_ctrl_rdy  in  1  IDELAYCTRL ready, asynchronous.
- rb_n  in  NUM_CHIPS  per-chip ready/busy (1 = ready), asynchronous.
- cmd_valid  out  1  command request to PHY.
- cmd_ready  in  1  PHY accepts command.
- cmd_chip  out  CW=max(1,$clog2(NUM_CHIPS))  target chip index.
- cmd_byte  out  8  command opcode, always 8'hFF.
- rstn_phy  out  1  active-low PHY reset.
- init_done  out  1  sequence complete, sticky.
- init_err  out  1  OR of err_chip_mask, valid when init_done.
- err_chip_mask  out  NUM_CHIPS  bit i set if chip i timed out.

## Operation
- Synchronizers: two-flop synchronizers on locked, idelay_ctrl_rdy, and each rb_n bit; the FSM reads only synchronized values. `ok` = locked_s & idelay_rdy_s.
- States: IDLE, SETTLE, ISSUE, WAIT_TWB, POLL, NEXT, DONE.
- IDLE: counters and chip index cleared. Goes to SETTLE when `ok`.
- SETTLE: counts `ok` cycles. If `ok` drops, the counter clears and the FSM returns to IDLE. At SETTLE_CYCLES the FSM goes to ISSUE and rstn_phy rises.
- ISSUE: cmd_valid=1, cmd_chip=idx, cmd_byte=8'hFF. On cmd_valid&cmd_ready the FSM goes to WAIT_TWB.
- WAIT_TWB: counts TWB_CYCLES, then goes to POLL with the poll counter cleared.
- POLL: if rb_n_s[idx]=1, go to NEXT. Otherwise increment the poll counter. When it reaches TIMEOUT_CYCLES, set err_chip_mask[idx] and go to NEXT.
- NEXT: if idx=NUM_CHIPS-1, go to DONE. Otherwise idx+1 and go to ISSUE.
- DONE: init_done=1 and init_err=|err_chip_mask. The FSM holds here until reset or abort.
- Abort: in any state other than IDLE, `ok`=0 forces IDLE in the next cycle. Abort clears rstn_phy, cmd_valid, init_done and err_chip_mask. Dropping cmd_valid without a handshake is allowed because the PHY is held in reset at the same time.
- Counters are 20-bit, saturating, and never wrap.

## Timing
- Reset values: cmd_valid=0, cmd_chip=0, cmd_byte=8'hFF, rstn_phy=0, init_done=0, init_err=0, err_chip_mask=0, state=IDLE.
- All outputs are registered.
- `ok` rise to SETTLE entry: 3 cycles (2 sync stages plus 1).
- SETTLE entry to rstn_phy=1 and cmd_valid=1: SETTLE_CYCLES cycles. Both outputs rise in the same cycle.
- cmd_valid, cmd_chip and cmd_byte stay stable until the handshake. cmd_valid falls in the cycle after the handshake.
- R/B# response latency is 2 sync cycles. A chip whose rb_n is already high is still subject to the tWB wait before it is sampled.
- Timeout fires exactly TIMEOUT_CYCLES cycles after POLL entry. If rb_n_s rises in the same cycle as the timeout, ready wins and the error bit is not set.
- DONE is reached 1 cycle after the last NEXT. init_done and init_err update together.
- An asynchronous assertion of rst_tmp clears all state immediately, mid-command included.

## Structure
- Package `nand_bringup_pkg`: state enum, CMD_RESET=8'hFF, counter width localparam (20).
- Sub-module `nand_sync2` (parameterized width, two-flop synchronizer, async reset to 0). It is instantiated for locked, idelay_ctrl_rdy and rb_n.

## Test plan
- Nominal, NUM_CHIPS=4, SETTLE=16, TWB=10, TIMEOUT=200, each chip busy 50 cycles after its command → four 0xFF commands with chip indices 0,1,2,3 → init_done=1, err_chip_mask=0.
- Chip 2 holds rb_n low → its POLL lasts exactly 200 cycles → err_chip_mask=4'b0100, init_err=1, chip 3 still commanded.
- cmd_ready held low for 30 cycles → cmd_valid, cmd_chip and cmd_byte stable throughout, exactly one handshake per chip.
- locked glitches low for 1 cycle mid-SETTLE → settle count restarts and rstn_phy rises SETTLE cycles after recovery. Same glitch during POLL → abort: rstn_phy=0, init_done=0, mask cleared, sequence restarts at chip 0.
- rst_tmp asserted in ISSUE → all outputs return to reset values in the same cycle (asynchronously).
- rb_n_s[idx] rises in the timeout cycle → no error bit set.

Source files
------------

// File: rtl/nand_bringup_pkg.sv
// nand_bringup_pkg: shared state encoding and constants for the NAND power-up sequencer
package nand_bringup_pkg;
  localparam int CNT_W = 20;
  localparam logic [7:0] CMD_RESET = 8'hFF;
  typedef enum logic [2:0] {IDLE, SETTLE, ISSUE, WAIT_TWB, POLL, NEXT, DONE} state_t;
endpackage

// File: rtl/nand_sync2.sv
// nand_sync2: two-flop synchronizer for asynchronous level inputs, cleared by reset
module nand_sync2 #(
  parameter int W = 1
) (
  input  logic         clk0,
  input  logic         rst_tmp,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_s1, r_s2;
  always_ff @(posedge clk0 or posedge rst_tmp)
    if (rst_tmp) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  assign o_q = r_s2;
endmodule

// File: rtl/nand_bringup_seq.sv
// nand_bringup_seq: waits for clocking ready, releases the PHY and resets each NAND chip with a timeout
module nand_bringup_seq
  import nand_bringup_pkg::*;
#(
  parameter  int NUM_CHIPS      = 8,
  parameter  int SETTLE_CYCLES  = 1000,
  parameter  int TWB_CYCLES     = 10,
  parameter  int TIMEOUT_CYCLES = 100000,
  localparam int CW             = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
  input  logic                 clk0,
  input  logic                 rst_tmp,
  input  logic                 locked,
  input  logic                 idelay_ctrl_rdy,
  input  logic [NUM_CHIPS-1:0] rb_n,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [CW-1:0]        cmd_chip,
  output logic [7:0]           cmd_byte,
  output logic                 rstn_phy,
  output logic                 init_done,
  output logic                 init_err,
  output logic [NUM_CHIPS-1:0] err_chip_mask
);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TWB_LAST    = CNT_W'(TWB_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]    LAST_CHIP   = CW'(NUM_CHIPS - 1);
  logic                 w_locked_s, w_idelay_s, w_ok;
  logic [NUM_CHIPS-1:0] w_rb_s;
  logic [CNT_W-1:0]     w_cnt_inc;
  state_t               r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [CW-1:0]        r_cmd_chip;
  logic                 r_cmd_valid, r_rstn_phy, r_init_done, r_init_err;
  logic [NUM_CHIPS-1:0] r_err;
  nand_sync2 #(.W(1)) u_sync_locked (.clk0(clk0), .rst_tmp(rst_tmp), .i_d(locked), .o_q(w_locked_s));
  nand_sync2 #(.W(1)) u_sync_idelay (.clk0(clk0), .rst_tmp(rst_tmp), .i_d(idelay_ctrl_rdy), .o_q(w_idelay_s));
  nand_sync2 #(.W(NUM_CHIPS)) u_sync_rb (.clk0(clk0), .rst_tmp(rst_tmp), .i_d(rb_n), .o_q(w_rb_s));
  assign w_ok      = w_locked_s & w_idelay_s;
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
  // r_cmd_chip doubles as the chip index; losing ok anywhere past IDLE aborts to a clean restart
  always_ff @(posedge clk0 or posedge rst_tmp)
    if (rst_tmp) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_chip  <= '0;
      r_cmd_valid <= 1'b0;
      r_rstn_phy  <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_err       <= '0;
    end else if (r_state != IDLE && !w_ok) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cmd_chip  <= '0;
      r_cmd_valid <= 1'b0;
      r_rstn_phy  <= 1'b0;
      r_init_done <= 1'b0;
      r_init_err  <= 1'b0;
      r_err       <= '0;
    end else
      case (r_state)
        IDLE: begin
          r_cnt      <= '0;
          r_cmd_chip <= '0;
          if (w_ok) r_state <= SETTLE;
        end
        SETTLE:
          if (r_cnt == SETTLE_LAST) begin
            r_state     <= ISSUE;
            r_cnt       <= '0;
            r_rstn_phy  <= 1'b1;
            r_cmd_valid <= 1'b1;
          end else r_cnt <= w_cnt_inc;
        ISSUE:
          if (cmd_ready) begin
            r_state     <= WAIT_TWB;
            r_cmd_valid <= 1'b0;
            r_cnt       <= '0;
          end
        WAIT_TWB:
          if (r_cnt == TWB_LAST) begin
            r_state <= POLL;
            r_cnt   <= '0;
          end else r_cnt <= w_cnt_inc;
        POLL:
          if (w_rb_s[r_cmd_chip]) r_state <= NEXT;
          else if (r_cnt == TO_LAST) begin
            r_err[r_cmd_chip] <= 1'b1;
            r_state           <= NEXT;
          end else r_cnt <= w_cnt_inc;
        NEXT:
          if (r_cmd_chip == LAST_CHIP) begin
            r_state     <= DONE;
            r_init_done <= 1'b1;
            r_init_err  <= |r_err;
          end else begin
            r_cmd_chip  <= r_cmd_chip + 1'b1;
            r_cmd_valid <= 1'b1;
            r_state     <= ISSUE;
          end
        DONE: r_state <= DONE;
        default: r_state <= IDLE;
      endcase
  assign cmd_valid     = r_cmd_valid;
  assign cmd_chip      = r_cmd_chip;
  assign cmd_byte      = CMD_RESET;
  assign rstn_phy      = r_rstn_phy;
  assign init_done     = r_init_done;
  assign init_err      = r_init_err;
  assign err_chip_mask = r_err;
endmodule

// File: tb/tb_nand_bringup_seq.sv
// tb_nand_bringup_seq: directed bring-up scenarios with a command scoreboard and a busy-chip model
module tb_nand_bringup_seq;
  localparam int NC = 4, ST = 16, TWB = 10, TO = 200;
  logic          clk0 = 1'b0, rst_tmp = 1'b1, locked = 1'b0, idelay_ctrl_rdy = 1'b1, cmd_ready = 1'b0;
  logic [NC-1:0] rb_n = '1;
  logic          cmd_valid, rstn_phy, init_done, init_err;
  logic [1:0]    cmd_chip;
  logic [7:0]    cmd_byte;
  logic [NC-1:0] err_chip_mask;
  int n_pass = 0, n_total = 0, hs_cnt = 0;
  int exp_q[$];
  int busy[NC];
  int busy_len[NC];

  nand_bringup_seq #(.NUM_CHIPS(NC), .SETTLE_CYCLES(ST), .TWB_CYCLES(TWB), .TIMEOUT_CYCLES(TO)) dut (
    .clk0(clk0), .rst_tmp(rst_tmp), .locked(locked), .idelay_ctrl_rdy(idelay_ctrl_rdy), .rb_n(rb_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_chip(cmd_chip), .cmd_byte(cmd_byte),
    .rstn_phy(rstn_phy), .init_done(init_done), .init_err(init_err), .err_chip_mask(err_chip_mask)
  );

  always #5 clk0 = ~clk0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: every handshake must match the next expected chip index
  initial forever begin
    @(negedge clk0);
    if (!rst_tmp && cmd_valid && cmd_ready) begin
      int e;
      hs_cnt++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
      chk("hs_chip", 32'(cmd_chip), e);
      chk("hs_byte", 32'(cmd_byte), 32'hFF);
    end
  end

  // Chip model: R/B# drops right after its command and returns after busy_len cycles
  initial begin
    bit hs;
    int ch;
    foreach (busy[i]) busy[i] = 0;
    forever begin
      @(negedge clk0);
      hs = cmd_valid && cmd_ready && !rst_tmp;
      ch = int'(cmd_chip);
      @(posedge clk0); #1;
      for (int i = 0; i < NC; i++) if (busy[i] > 0) busy[i]--;
      if (hs) busy[ch] = busy_len[ch];
      for (int i = 0; i < NC; i++) rb_n[i] = (busy[i] == 0);
    end
  end

  task automatic push_all();
    for (int i = 0; i < NC; i++) exp_q.push_back(i);
  endtask

  task automatic restart(string tag);
    @(negedge clk0);
    exp_q.delete();
    hs_cnt = 0;
    foreach (busy[i]) busy[i] = 0;
    rst_tmp = 1'b1;
    #1;
    chk({tag, "_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_rstn"}, 32'(rstn_phy), 0);
    chk({tag, "_done"}, 32'(init_done), 0);
    chk({tag, "_err"}, 32'(init_err), 0);
    chk({tag, "_mask"}, 32'(err_chip_mask), 0);
    chk({tag, "_chip"}, 32'(cmd_chip), 0);
    @(negedge clk0);
    rst_tmp = 1'b0;
  endtask

  // Called at posedge+1: one-cycle locked drop, then abort and re-settle timing
  task automatic glitch(string tag, bit rstn_before);
    locked = 1'b0;
    @(posedge clk0); #1 locked = 1'b1;
    @(posedge clk0); @(negedge clk0);
    chk({tag, "_pre_rstn"}, 32'(rstn_phy), 32'(rstn_before));
    @(posedge clk0); @(negedge clk0);
    chk({tag, "_ab_rstn"}, 32'(rstn_phy), 0);
    chk({tag, "_ab_valid"}, 32'(cmd_valid), 0);
    chk({tag, "_ab_done"}, 32'(init_done), 0);
    chk({tag, "_ab_err"}, 32'(init_err), 0);
    chk({tag, "_ab_mask"}, 32'(err_chip_mask), 0);
    repeat (16) @(posedge clk0);
    @(negedge clk0);
    chk({tag, "_early_rstn"}, 32'(rstn_phy), 0);
    @(negedge clk0);
    chk({tag, "_rise_rstn"}, 32'(rstn_phy), 1);
    chk({tag, "_rise_valid"}, 32'(cmd_valid), 1);
  endtask

  task automatic wait_done(string tag, int budget);
    int n = 0;
    while (!init_done && n < budget) begin
      @(negedge clk0);
      n++;
    end
    chk(tag, 32'(init_done), 1);
  endtask

  initial begin
    int stable;
    int n;
    foreach (busy_len[i]) busy_len[i] = 50;
    repeat (2) @(negedge clk0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_chip", 32'(cmd_chip), 0);
    chk("rst_byte", 32'(cmd_byte), 32'hFF);
    chk("rst_rstn", 32'(rstn_phy), 0);
    chk("rst_done", 32'(init_done), 0);
    chk("rst_err", 32'(init_err), 0);
    chk("rst_mask", 32'(err_chip_mask), 0);
    @(negedge clk0) rst_tmp = 1'b0;
    // Nominal run with a mid-settle glitch and a stalled first handshake
    push_all();
    @(posedge clk0); #1 locked = 1'b1;
    repeat (10) @(posedge clk0);
    #1;
    glitch("settle_glitch", 1'b0);
    stable = 0;
    repeat (30) begin
      @(negedge clk0);
      if (cmd_valid === 1'b1 && cmd_chip === 2'd0 && cmd_byte === 8'hFF) stable++;
    end
    chk("hold_stable", stable, 30);
    @(posedge clk0); #1 cmd_ready = 1'b1;
    wait_done("nominal_done", 2000);
    chk("nominal_mask", 32'(err_chip_mask), 0);
    chk("nominal_err", 32'(init_err), 0);
    chk("nominal_hs", hs_cnt, NC);
    chk("nominal_qleft", exp_q.size(), 0);
    repeat (5) @(negedge clk0);
    chk("done_sticky", 32'(init_done), 1);
    // Chip 2 stuck busy; chip 1 becomes ready exactly on the timeout cycle
    busy_len[1] = 207;
    busy_len[2] = 100000;
    restart("rst_from_done");
    push_all();
    wait_done("to_done", 3000);
    chk("to_mask", 32'(err_chip_mask), 32'b0100);
    chk("to_err", 32'(init_err), 1);
    chk("to_hs", hs_cnt, NC);
    chk("to_qleft", exp_q.size(), 0);
    // Abort from DONE, then a clean rerun
    busy_len[2] = 50;
    exp_q.delete();
    push_all();
    hs_cnt = 0;
    @(posedge clk0); #1;
    glitch("done_abort", 1'b1);
    wait_done("rerun_done", 3000);
    chk("rerun_mask", 32'(err_chip_mask), 0);
    chk("rerun_err", 32'(init_err), 0);
    chk("rerun_hs", hs_cnt, NC);
    // Chip 1 misses the timeout by one cycle; abort while chip 2 is polled
    busy_len[1] = 208;
    restart("rst3");
    push_all();
    n = 0;
    while (hs_cnt < 3 && n < 1000) begin
      @(negedge clk0);
      n++;
    end
    chk("poll_reach", 32'(hs_cnt >= 3), 1);
    repeat (15) @(posedge clk0);
    @(negedge clk0);
    chk("pre_abort_mask", 32'(err_chip_mask), 32'b0010);
    exp_q.delete();
    push_all();
    hs_cnt = 0;
    @(posedge clk0); #1;
    glitch("poll_abort", 1'b1);
    wait_done("late_done", 3000);
    chk("late_mask", 32'(err_chip_mask), 32'b0010);
    chk("late_err", 32'(init_err), 1);
    chk("late_hs", hs_cnt, NC);
    // Asynchronous reset while a command is pending
    cmd_ready = 1'b0;
    restart("rst4");
    n = 0;
    while (cmd_valid !== 1'b1 && n < 60) begin
      @(negedge clk0);
      n++;
    end
    chk("issue_reach", 32'(cmd_valid), 1);
    restart("rst_in_issue");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
